issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_pkg.sv | 20 ++
 rtl/issue_queue_oldest_select.sv | 31 +++
 rtl/issue_queue.sv | 181 ++++++++++++++++++
 tb/tb_issue_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the ROB, LSB, ALU and issue queue.
// TAG_NULL_ALL is a wide all-ones constant. Each block slices it down to its
// own tag width, so "value present" is always the all-ones tag whatever
// TAG_W a block uses.
package issue_queue_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] TAG_NULL_ALL = '1;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 6'h00,
    OP_SUB    = 6'h01,
    OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BRANCH, OP_LOAD, OP_STORE
  } op_e;
endpackage

// File: rtl/issue_queue_oldest_select.sv
// iq_oldest_select: purely combinational oldest-first picker.
// Ports: eligible - per-entry eligible flags
//        rank     - per-entry age rank (0 = oldest, unique among valid)
//        index    - entry with the smallest rank among the eligible ones
//        found    - high when at least one entry is eligible
module iq_oldest_select
  import issue_queue_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [N-1:0][IW-1:0] rank,
  output logic [IW-1:0]        index,
  output logic                 found
);
  logic [IW-1:0] best;

  always_comb begin
    index = '0;
    found = FALSE;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!found || rank[i] < best)) begin
        index = IW'(i);
        best  = rank[i];
        found = TRUE;
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: reservation station in front of the ALU.
// Dispatch writes into the lowest free slot; operands wake up from NUM_CDB
// broadcast channels, bypassing on the dispatch cycle too. Each cycle the
// oldest entry whose operands are both present is moved into a registered
// issue slot (valid/ready handshake).
// Ports: clk_in/rst_in (async active-low)/rdy_in (global stall)/flush_in,
//        disp_* dispatch handshake and payload, cdb_* packed broadcasts,
//        iss_* issue handshake and payload, count_out occupancy.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int TAG_W    = 6,
  parameter int XLEN     = 32,
  parameter int NUM_CDB  = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      disp_valid_in,
  output logic                      disp_ready_out,
  input  logic [OP_W-1:0]           disp_op_in,
  input  logic [31:0]               disp_inst_in,
  input  logic [31:0]               disp_pc_in,
  input  logic [31:0]               disp_imm_in,
  input  logic [TAG_W-1:0]          disp_tag_in,
  input  logic [TAG_W-1:0]          disp_qj_in,
  input  logic [TAG_W-1:0]          disp_qk_in,
  input  logic [XLEN-1:0]           disp_vj_in,
  input  logic [XLEN-1:0]           disp_vk_in,
  input  logic [NUM_CDB-1:0]        cdb_valid_in,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_in,
  input  logic [NUM_CDB*XLEN-1:0]   cdb_value_in,
  output logic                      iss_valid_out,
  input  logic                      iss_ready_in,
  output logic [OP_W-1:0]           iss_op_out,
  output logic [31:0]               iss_inst_out,
  output logic [XLEN-1:0]           iss_vj_out,
  output logic [XLEN-1:0]           iss_vk_out,
  output logic [31:0]               iss_imm_out,
  output logic [31:0]               iss_pc_out,
  output logic [TAG_W-1:0]          iss_tag_out,
  output logic [$clog2(RS_DEPTH):0] count_out
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [TAG_W-1:0] TAG_NULL = TAG_NULL_ALL[TAG_W-1:0];

  logic [RS_DEPTH-1:0]             valid;
  logic [RS_DEPTH-1:0][OP_W-1:0]   op;
  logic [RS_DEPTH-1:0][31:0]       inst, pc, imm;
  logic [RS_DEPTH-1:0][TAG_W-1:0]  tag, qj, qk;
  logic [RS_DEPTH-1:0][XLEN-1:0]   vj, vk;
  logic [RS_DEPTH-1:0][IW-1:0]     rank;

  logic [RS_DEPTH-1:0][TAG_W-1:0]  qj_nx, qk_nx;
  logic [RS_DEPTH-1:0][XLEN-1:0]   vj_nx, vk_nx;
  logic [TAG_W-1:0]                dqj, dqk;
  logic [XLEN-1:0]                 dvj, dvk;
  logic [RS_DEPTH-1:0]             eligible;
  logic [IW-1:0]                   sel_idx, sel_rank, free_idx, new_rank;
  logic                            sel_found, iss_load, iss_fire, accept;

  // Operand capture from the broadcast bus. Null-tagged broadcasts never
  // match; the first (lowest) matching channel supplies the value.
  function automatic logic [TAG_W+XLEN-1:0] wake(
    input logic [TAG_W-1:0]         q,
    input logic [XLEN-1:0]          v,
    input logic [NUM_CDB-1:0]       cv,
    input logic [NUM_CDB*TAG_W-1:0] ct,
    input logic [NUM_CDB*XLEN-1:0]  cval
  );
    logic hit;
    hit  = FALSE;
    wake = {q, v};
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!hit && cv[c] && ct[c*TAG_W +: TAG_W] != TAG_NULL &&
          ct[c*TAG_W +: TAG_W] == q) begin
        hit  = TRUE;
        wake = {TAG_NULL, cval[c*XLEN +: XLEN]};
      end
    end
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      {qj_nx[i], vj_nx[i]} = wake(qj[i], vj[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
      {qk_nx[i], vk_nx[i]} = wake(qk[i], vk[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
      // Registered tags only: a wakeup this cycle issues next cycle.
      eligible[i] = valid[i] && qj[i] == TAG_NULL && qk[i] == TAG_NULL;
    end
    {dqj, dvj} = wake(disp_qj_in, disp_vj_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    {dqk, dvk} = wake(disp_qk_in, disp_vk_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IW'(i);
  end

  iq_oldest_select #(.N(RS_DEPTH), .IW(IW)) u_sel (
    .eligible (eligible),
    .rank     (rank),
    .index    (sel_idx),
    .found    (sel_found)
  );

  assign sel_rank       = rank[sel_idx];
  assign disp_ready_out = count_out < CW'(RS_DEPTH);
  assign iss_load       = rdy_in && !flush_in && (!iss_valid_out || iss_ready_in);
  assign iss_fire       = iss_load && sel_found;
  // Uses occupancy before this cycle's issue, so a full queue never accepts.
  assign accept         = rdy_in && !flush_in && disp_valid_in && disp_ready_out;
  // Newcomer is the youngest among what remains after this cycle's issue.
  assign new_rank       = IW'(count_out - CW'(iss_fire));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid         <= '0;
      op            <= '0;
      inst          <= '0;
      pc            <= '0;
      imm           <= '0;
      tag           <= '0;
      qj            <= '0;
      qk            <= '0;
      vj            <= '0;
      vk            <= '0;
      rank          <= '0;
      count_out     <= '0;
      iss_valid_out <= FALSE;
      iss_op_out    <= '0;
      iss_inst_out  <= '0;
      iss_vj_out    <= '0;
      iss_vk_out    <= '0;
      iss_imm_out   <= '0;
      iss_pc_out    <= '0;
      iss_tag_out   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        valid         <= '0;
        count_out     <= '0;
        iss_valid_out <= FALSE;
      end else begin
        qj <= qj_nx;
        vj <= vj_nx;
        qk <= qk_nx;
        vk <= vk_nx;
        // Close the gap left by the issued entry to keep ranks dense.
        for (int i = 0; i < RS_DEPTH; i++)
          if (iss_fire && valid[i] && rank[i] > sel_rank) rank[i] <= rank[i] - IW'(1);
        if (iss_load) begin
          iss_valid_out <= sel_found;
          if (sel_found) begin
            valid[sel_idx] <= FALSE;
            iss_op_out     <= op[sel_idx];
            iss_inst_out   <= inst[sel_idx];
            iss_vj_out     <= vj[sel_idx];
            iss_vk_out     <= vk[sel_idx];
            iss_imm_out    <= imm[sel_idx];
            iss_pc_out     <= pc[sel_idx];
            iss_tag_out    <= tag[sel_idx];
          end
        end
        if (accept) begin
          valid[free_idx] <= TRUE;
          op[free_idx]    <= disp_op_in;
          inst[free_idx]  <= disp_inst_in;
          pc[free_idx]    <= disp_pc_in;
          imm[free_idx]   <= disp_imm_in;
          tag[free_idx]   <= disp_tag_in;
          qj[free_idx]    <= dqj;
          vj[free_idx]    <= dvj;
          qk[free_idx]    <= dqk;
          vk[free_idx]    <= dvk;
          rank[free_idx]  <= new_rank;
        end
        count_out <= count_out + CW'(accept) - CW'(iss_fire);
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic, compared
// cycle by cycle against an age-ordered list model of the queue.
module tb_issue_queue;
  localparam int N  = 16;
  localparam int TW = 6;
  localparam int XL = 32;
  localparam int NC = 3;
  localparam logic [TW-1:0] TNULL = '1;

  logic clk = 1'b0;
  logic rst_n, rdy, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [5:0]       disp_op, iss_op;
  logic [31:0]      disp_inst, disp_pc, disp_imm, iss_inst, iss_pc, iss_imm;
  logic [TW-1:0]    disp_tag, disp_qj, disp_qk, iss_tag;
  logic [XL-1:0]    disp_vj, disp_vk, iss_vj, iss_vk;
  logic [NC-1:0]    cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*XL-1:0] cdb_value;
  logic [4:0]       count;

  always #5 clk = ~clk;

  issue_queue #(.RS_DEPTH(N), .TAG_W(TW), .XLEN(XL), .NUM_CDB(NC)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .disp_valid_in(disp_valid), .disp_ready_out(disp_ready),
    .disp_op_in(disp_op), .disp_inst_in(disp_inst), .disp_pc_in(disp_pc),
    .disp_imm_in(disp_imm), .disp_tag_in(disp_tag), .disp_qj_in(disp_qj),
    .disp_qk_in(disp_qk), .disp_vj_in(disp_vj), .disp_vk_in(disp_vk),
    .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_value_in(cdb_value),
    .iss_valid_out(iss_valid), .iss_ready_in(iss_ready),
    .iss_op_out(iss_op), .iss_inst_out(iss_inst), .iss_vj_out(iss_vj),
    .iss_vk_out(iss_vk), .iss_imm_out(iss_imm), .iss_pc_out(iss_pc),
    .iss_tag_out(iss_tag), .count_out(count)
  );

  typedef struct packed {
    logic [5:0]    op;
    logic [31:0]   inst, pc, imm;
    logic [TW-1:0] tag, qj, qk;
    logic [XL-1:0] vj, vk;
  } ent_t;

  ent_t mq[$];      // model entries, oldest at the front
  ent_t m_iss;
  bit   m_iss_v;
  int   n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [TW+XL-1:0] woke(input logic [TW-1:0] q, input logic [XL-1:0] v);
    for (int c = 0; c < NC; c++)
      if (cdb_valid[c] && cdb_tag[c*TW +: TW] != TNULL && cdb_tag[c*TW +: TW] == q)
        return {TNULL, cdb_value[c*XL +: XL]};
    return {q, v};
  endfunction

  task automatic model_step();
    int   sz;
    int   pick;
    ent_t e;
    sz   = mq.size();
    pick = -1;
    if (!rdy) return;
    if (flush) begin
      mq.delete();
      m_iss_v = 0;
      return;
    end
    if (!m_iss_v || iss_ready) begin
      foreach (mq[i]) if (pick < 0 && mq[i].qj == TNULL && mq[i].qk == TNULL) pick = i;
      m_iss_v = (pick >= 0);
      if (pick >= 0) begin
        m_iss = mq[pick];
        mq.delete(pick);
      end
    end
    foreach (mq[i]) begin
      e = mq[i];
      {e.qj, e.vj} = woke(e.qj, e.vj);
      {e.qk, e.vk} = woke(e.qk, e.vk);
      mq[i] = e;
    end
    if (disp_valid && sz < N) begin
      e.op = disp_op; e.inst = disp_inst; e.pc = disp_pc; e.imm = disp_imm;
      e.tag = disp_tag;
      {e.qj, e.vj} = woke(disp_qj, disp_vj);
      {e.qk, e.vk} = woke(disp_qk, disp_vk);
      mq.push_back(e);
    end
  endtask

  task automatic check_outputs();
    chk("count", count, mq.size());
    chk("disp_ready", disp_ready, mq.size() < N);
    chk("iss_valid", iss_valid, m_iss_v);
    if (m_iss_v) begin
      chk("iss_tag", iss_tag, m_iss.tag);
      chk("iss_op", iss_op, m_iss.op);
      chk("iss_vj", iss_vj, m_iss.vj);
      chk("iss_vk", iss_vk, m_iss.vk);
      chk("iss_pc", iss_pc, m_iss.pc);
      chk("iss_imm", iss_imm, m_iss.imm);
      chk("iss_inst", iss_inst, m_iss.inst);
    end
  endtask

  // Called at posedge+1 with inputs already set for the coming edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rdy = 1; flush = 0; disp_valid = 0; cdb_valid = '0;
  endtask

  task automatic disp(input logic [TW-1:0] t, input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                      input logic [XL-1:0] vj, input logic [XL-1:0] vk);
    disp_valid = 1; disp_tag = t; disp_qj = qj; disp_qk = qk; disp_vj = vj; disp_vk = vk;
    disp_op = 6'($urandom); disp_inst = $urandom; disp_pc = $urandom; disp_imm = $urandom;
  endtask

  task automatic bcast(input int ch, input logic [TW-1:0] t, input logic [XL-1:0] v);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TW +: TW] = t;
    cdb_value[ch*XL +: XL] = v;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; m_iss_v = 0; m_iss = '0;
    rst_n = 0; idle(); iss_ready = 0;
    disp_op = '0; disp_inst = '0; disp_pc = '0; disp_imm = '0; disp_tag = '0;
    disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0;
    cdb_tag = '0; cdb_value = '0;

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_tag", iss_tag, 0);
    chk("rst_iss_vj", iss_vj, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", disp_ready, 1);

    // Fill with issue stalled: tag 0 sits in the issue slot, 16 behind it
    iss_ready = 0;
    for (int t = 0; t <= 16; t++) begin
      idle(); disp(TW'(t), TNULL, TNULL, XL'(t * 3), XL'(t * 5)); cycle();
    end
    chk("full_count", count, 16);
    chk("full_ready", disp_ready, 0);
    chk("held_tag", iss_tag, 0);
    idle(); disp(6'd17, TNULL, TNULL, 1, 2); cycle();
    chk("full_reject", count, 16);
    chk("held_tag2", iss_tag, 0);

    // Full queue: issue and dispatch in the same cycle
    idle(); disp(6'd18, TNULL, TNULL, 1, 2); iss_ready = 1; cycle();
    chk("full_iss_count", count, 15);
    chk("full_iss_tag", iss_tag, 1);
    idle();
    repeat (18) cycle();
    chk("drained", count, 0);

    // Wakeup ordering: younger ready op issues first
    idle(); disp(6'd5, 6'd3, TNULL, 0, 32'h22); cycle();
    idle(); disp(6'd6, TNULL, TNULL, 1, 2); cycle();
    idle(); bcast(1, 6'd3, 32'hAB); cycle();
    chk("wk_first", iss_tag, 6);
    idle(); cycle();
    chk("wk_second", iss_tag, 5);
    chk("wk_vj", iss_vj, 32'hAB);
    idle(); cycle();

    // Dispatch-cycle bypass
    idle(); disp(6'd9, TNULL, 6'd7, 1, 0); bcast(0, 6'd7, 32'h55); cycle();
    idle(); cycle();
    chk("byp_tag", iss_tag, 9);
    chk("byp_vk", iss_vk, 32'h55);
    idle(); bcast(0, 6'd7, 32'h99); cycle();

    // Multi-channel match and null-tagged broadcast
    idle(); disp(6'd10, 6'd4, TNULL, 0, 3); cycle();
    idle(); bcast(2, 6'd4, 32'h22); bcast(1, 6'd4, 32'h11);
    disp(6'd11, TNULL, TNULL, 5, 6); bcast(0, TNULL, 32'hEE); cycle();
    idle(); cycle();
    chk("lowch_vj", iss_vj, 32'h11);
    idle(); repeat (3) cycle();

    // Flush with four entries and a held issue
    iss_ready = 0;
    for (int t = 20; t < 25; t++) begin
      idle(); disp(TW'(t), TNULL, TNULL, XL'(t), XL'(t)); cycle();
    end
    chk("pre_flush_count", count, 4);
    idle(); flush = 1; disp(6'd30, TNULL, TNULL, 1, 1); cycle();
    chk("flush_count", count, 0);
    chk("flush_iss", iss_valid, 0);
    idle(); cycle();
    chk("flush_drop", count, 0);

    // Stall holds everything, including broadcast capture
    iss_ready = 1;
    idle(); disp(6'd40, 6'd2, TNULL, 0, 9); cycle();
    idle(); rdy = 0; bcast(0, 6'd2, 32'h77); disp(6'd41, TNULL, TNULL, 1, 1);
    repeat (3) cycle();
    chk("stall_count", count, 1);
    idle(); repeat (2) cycle();
    chk("stall_wait", iss_valid, 0);
    idle(); bcast(0, 6'd2, 32'h78); cycle();
    idle(); cycle();
    chk("stall_tag", iss_tag, 40);
    chk("stall_vj", iss_vj, 32'h78);

    // Asynchronous reset mid-operation
    iss_ready = 0;
    for (int t = 0; t < 3; t++) begin
      idle(); disp(TW'(t + 50), TNULL, TNULL, 1, 1); cycle();
    end
    idle();
    rst_n = 0;
    #2;
    chk("async_count", count, 0);
    chk("async_iss", iss_valid, 0);
    chk("async_tag", iss_tag, 0);
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete(); m_iss_v = 0;
    idle(); cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rdy = ($urandom_range(7) != 0);
      flush = ($urandom_range(63) == 0);
      iss_ready = ($urandom_range(9) < 7);
      if ($urandom_range(9) < 6)
        disp(TW'($urandom_range(15)),
             ($urandom_range(1) != 0) ? TNULL : TW'($urandom_range(7)),
             ($urandom_range(1) != 0) ? TNULL : TW'($urandom_range(7)),
             $urandom, $urandom);
      for (int c = 0; c < NC; c++)
        if ($urandom_range(9) < 3)
          bcast(c, ($urandom_range(9) == 0) ? TNULL : TW'($urandom_range(7)), $urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
